// File: rtl/uart_rx.sv
// 16x oversampled UART receiver with mid-bit sampling and valid/read handshake.
// Define UART_RX_PARITY_EN to receive and check an even-parity bit.
module uart_rx #(
    parameter int N         = 8,
    parameter int M         = 1,
    parameter int BAUD_RATE = 9600,
    parameter int CLK_FREQ  = 50000000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         rx,
    input  logic         rd,
    output logic [N-1:0] data_out,
    output logic         data_valid,
    output logic         frame_err,
    output logic         parity_err,
    output logic         overrun_err,
    output logic         busy
);

    localparam int DIV = CLK_FREQ / (BAUD_RATE * 16);
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BW  = $clog2(N + 2);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    logic          rx_m;
    logic          rx_s;
    logic [DW-1:0] div_cnt;
    logic          tick;
    logic [3:0]    s_cnt;
    logic [BW-1:0] bit_cnt;
    logic [2:0]    state;
    logic [N-1:0]  sreg;
    logic [N-1:0]  msb;
    logic          ferr_acc;
    logic          arm;
    logic          done;
    logic          perr_calc;
`ifdef UART_RX_PARITY_EN
    logic          par_bit;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    assign tick = (div_cnt == DW'(DIV - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)     div_cnt <= '0;
        else if (tick) div_cnt <= '0;
        else           div_cnt <= div_cnt + DW'(1);
    end

    // New bit lands in the MSB; written this way so N=1 needs no special case
    assign msb = N'({rx_s, {N{1'b0}}} >> 1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            s_cnt    <= '0;
            bit_cnt  <= '0;
            sreg     <= '0;
            ferr_acc <= 1'b0;
            arm      <= 1'b0;
            done     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit  <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            if (tick && rx_s) arm <= 1'b1;
            if (tick) begin
                unique case (state)
                    IDLE: begin
                        if (arm && !rx_s) begin
                            state    <= START;
                            s_cnt    <= '0;
                            ferr_acc <= 1'b0;
                        end
                    end
                    START: begin
                        if (s_cnt == 4'd7) begin
                            if (rx_s) begin
                                state <= IDLE;
                            end else begin
                                state   <= DATA;
                                s_cnt   <= '0;
                                bit_cnt <= '0;
                            end
                        end else begin
                            s_cnt <= s_cnt + 4'd1;
                        end
                    end
                    DATA: begin
                        s_cnt <= s_cnt + 4'd1;
                        if (s_cnt == 4'd15) begin
                            sreg <= (sreg >> 1) | msb;
                            if (bit_cnt == BW'(N - 1)) begin
                                bit_cnt <= '0;
`ifdef UART_RX_PARITY_EN
                                state   <= PARITY;
`else
                                state   <= STOP;
`endif
                            end else begin
                                bit_cnt <= bit_cnt + BW'(1);
                            end
                        end
                    end
`ifdef UART_RX_PARITY_EN
                    PARITY: begin
                        s_cnt <= s_cnt + 4'd1;
                        if (s_cnt == 4'd15) begin
                            par_bit <= rx_s;
                            state   <= STOP;
                        end
                    end
`endif
                    STOP: begin
                        s_cnt <= s_cnt + 4'd1;
                        if (s_cnt == 4'd15) begin
                            ferr_acc <= ferr_acc | !rx_s;
                            if (bit_cnt == BW'(M - 1)) begin
                                state <= IDLE;
                                done  <= 1'b1;
                                // A broken frame disarms until the line idles high
                                if (ferr_acc || !rx_s) arm <= 1'b0;
                            end else begin
                                bit_cnt <= bit_cnt + BW'(1);
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    assign perr_calc = (^sreg) != par_bit;
`else
    assign perr_calc = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out    <= '0;
            data_valid  <= 1'b0;
            frame_err   <= 1'b0;
            parity_err  <= 1'b0;
            overrun_err <= 1'b0;
        end else if (done) begin
            data_out   <= sreg;
            data_valid <= 1'b1;
            frame_err  <= ferr_acc;
            parity_err <= perr_calc;
            if (data_valid && !rd)     overrun_err <= 1'b1;
            else if (data_valid && rd) overrun_err <= 1'b0;
        end else if (rd && data_valid) begin
            data_valid  <= 1'b0;
            overrun_err <= 1'b0;
        end
    end

    // Held high through the completion cycle so it drops as data_valid rises
    assign busy = (state != IDLE) || done;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: vector table, corner-case sequences and random frames.
// Expected words come from the frame contents the bench itself transmits.
module tb_uart_rx;

    localparam int N   = 8;
    localparam int M   = 1;
    localparam int BIT = 160;
`ifdef UART_RX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         rx = 1'b1;
    logic         rd = 1'b0;
    logic [N-1:0] data_out;
    logic         data_valid;
    logic         frame_err;
    logic         parity_err;
    logic         overrun_err;
    logic         busy;

    uart_rx #(
        .N(N), .M(M), .BAUD_RATE(10000), .CLK_FREQ(1600000)
    ) dut (
        .clk(clk), .reset(reset), .rx(rx), .rd(rd),
        .data_out(data_out), .data_valid(data_valid),
        .frame_err(frame_err), .parity_err(parity_err),
        .overrun_err(overrun_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   rise_n = 0;
    int   rise_cyc = 0;
    int   busy_n = 0;
    logic dv_q = 1'b0;
    always @(negedge clk) begin
        if (data_valid && !dv_q) begin
            rise_n   = rise_n + 1;
            rise_cyc = cyc;
        end
        dv_q = data_valid;
        if (busy) busy_n = busy_n + 1;
    end

    int n_chk = 0;
    int n_fail = 0;
    int start_cyc = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Caller is at a negedge; returns at a negedge with rx left at the stop level
    task automatic send_frame(input logic [N-1:0] d, input logic stop, input logic pinv);
        rx = 1'b0;
        start_cyc = cyc;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < N; i++) begin
            rx = d[i];
            repeat (BIT) @(negedge clk);
        end
`ifdef UART_RX_PARITY_EN
        rx = (^d) ^ pinv;
        repeat (BIT) @(negedge clk);
`else
        if (pinv) rx = 1'b0;
`endif
        for (int i = 0; i < M; i++) begin
            rx = stop;
            repeat (BIT) @(negedge clk);
        end
    endtask

    task automatic wait_dv(input string nm, input int budget);
        int k;
        k = 0;
        while (!data_valid && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk({nm, "_valid"}, 32'(data_valid), 32'd1);
    endtask

    task automatic read_word(input string nm, input logic [N-1:0] ed,
                             input logic ef, input logic ep);
        wait_dv(nm, 4000);
        chk({nm, "_data"}, 32'(data_out), 32'(ed));
        chk({nm, "_ferr"}, 32'(frame_err), 32'(ef));
        chk({nm, "_perr"}, 32'(parity_err), 32'(ep));
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        chk({nm, "_rd_clr"}, 32'(data_valid), 32'd0);
    endtask

    typedef struct {
        logic [N-1:0] d;
        logic         stop;
        logic         pinv;
        logic [N-1:0] ed;
        logic         ef;
        logic         ep;
    } vec_t;

    vec_t         tbl[5];
    logic [N-1:0] rbytes[12];
    int           rgaps[12];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat, b0, r0, s1, off, s2, tgt;

        tbl[0] = '{8'hA5, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0};
        tbl[1] = '{8'h07, 1'b1, 1'b1, 8'h07, 1'b0, 1'(P)};
        tbl[2] = '{8'h07, 1'b1, 1'b0, 8'h07, 1'b0, 1'b0};
        tbl[3] = '{8'h5A, 1'b0, 1'b0, 8'h5A, 1'b1, 1'b0};
        tbl[4] = '{8'hFF, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0};

        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(data_valid), 32'd0);
        chk("rst_data", 32'(data_out), 32'd0);
        chk("rst_ferr", 32'(frame_err), 32'd0);
        chk("rst_perr", 32'(parity_err), 32'd0);
        chk("rst_ovr", 32'(overrun_err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        repeat (BIT) @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            send_frame(tbl[i].d, tbl[i].stop, tbl[i].pinv);
            rx = 1'b1;
            read_word($sformatf("vec%0d", i), tbl[i].ed, tbl[i].ef, tbl[i].ep);
            chk($sformatf("vec%0d_ovr", i), 32'(overrun_err), 32'd0);
            if (i == 0) begin
                lat = rise_cyc - start_cyc;
                chk("latency", 32'(lat >= 1520 + 160 * P && lat <= 1536 + 160 * P), 32'd1);
            end
            repeat (BIT) @(negedge clk);
        end

        fork
            begin
                send_frame(8'h00, 1'b1, 1'b0);
                send_frame(8'hFF, 1'b1, 1'b0);
                rx = 1'b1;
            end
            begin
                read_word("b2b0", 8'h00, 1'b0, 1'b0);
                read_word("b2b1", 8'hFF, 1'b0, 1'b0);
            end
        join
        repeat (BIT) @(negedge clk);

        b0 = busy_n;
        r0 = rise_n;
        rx = 1'b0;
        repeat (40) @(negedge clk);
        rx = 1'b1;
        repeat (2 * BIT) @(negedge clk);
        chk("glitch_busy_seen", 32'(busy_n > b0), 32'd1);
        chk("glitch_busy_low", 32'(busy), 32'd0);
        chk("glitch_no_word", 32'(rise_n - r0), 32'd0);

        r0 = rise_n;
        send_frame(8'h3C, 1'b0, 1'b0);
        read_word("brk", 8'h3C, 1'b1, 1'b0);
        repeat (3000) @(negedge clk);
        chk("brk_one_word", 32'(rise_n - r0), 32'd1);
        rx = 1'b1;
        repeat (2 * BIT) @(negedge clk);
        chk("brk_no_more", 32'(data_valid), 32'd0);

        send_frame(8'h11, 1'b1, 1'b0);
        rx = 1'b1;
        repeat (BIT) @(negedge clk);
        send_frame(8'h22, 1'b1, 1'b0);
        rx = 1'b1;
        repeat (BIT) @(negedge clk);
        chk("ovr_valid", 32'(data_valid), 32'd1);
        chk("ovr_data", 32'(data_out), 32'h22);
        chk("ovr_flag", 32'(overrun_err), 32'd1);
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        chk("ovr_rd_clr", 32'(overrun_err), 32'd0);
        chk("ovr_rd_valid", 32'(data_valid), 32'd0);
        repeat (BIT) @(negedge clk);

        // Second frame starts at the same divider phase, so its completion
        // edge sits at the same offset measured on the first frame.
        s1 = cyc;
        send_frame(8'h11, 1'b1, 1'b0);
        rx = 1'b1;
        wait_dv("coin0", 4000);
        repeat (2) @(negedge clk);
        off = rise_cyc - s1;
        repeat (BIT) @(negedge clk);
        while ((cyc - s1) % 10 != 0) @(negedge clk);
        s2 = cyc;
        tgt = s2 + off - 1;
        fork
            send_frame(8'h22, 1'b1, 1'b0);
            begin
                while (cyc < tgt) @(negedge clk);
                rd = 1'b1;
                @(negedge clk);
                rd = 1'b0;
            end
        join
        rx = 1'b1;
        repeat (4) @(negedge clk);
        chk("coin_valid", 32'(data_valid), 32'd1);
        chk("coin_data", 32'(data_out), 32'h22);
        chk("coin_ovr", 32'(overrun_err), 32'd0);

        rx = 1'b0;
        repeat (BIT) @(negedge clk);
        rx = 1'b1;
        repeat (BIT) @(negedge clk);
        rx = 1'b0;
        repeat (BIT + 40) @(negedge clk);
        chk("mid_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(data_valid), 32'd0);
        chk("mid_rst_data", 32'(data_out), 32'd0);
        chk("mid_rst_errs", 32'({frame_err, parity_err, overrun_err}), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        rx = 1'b1;
        repeat (2 * BIT) @(negedge clk);
        send_frame(8'hC3, 1'b1, 1'b0);
        rx = 1'b1;
        read_word("post_rst", 8'hC3, 1'b0, 1'b0);
        repeat (BIT) @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            rbytes[i] = 8'($urandom);
            rgaps[i]  = (i % 3 == 0) ? 0 : int'($urandom_range(0, 200));
        end
        fork
            for (int i = 0; i < 12; i++) begin
                send_frame(rbytes[i], 1'b1, 1'b0);
                rx = 1'b1;
                repeat (rgaps[i]) @(negedge clk);
            end
            for (int i = 0; i < 12; i++)
                read_word($sformatf("rnd%0d", i), rbytes[i], 1'b0, 1'b0);
        join
        chk("rnd_ovr", 32'(overrun_err), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Asynchronous serial receiver, the receive-side counterpart of the team's UART transmitter. It recovers frames from the `rx` line using 16x oversampling and mid-bit sampling. Each frame is 1 start bit, N data bits sent LSB first, an optional even-parity bit, and M stop bits. Received bytes are held in an output register with a valid/read handshake, and framing, parity and overrun errors are flagged. It sits between the pad-side `rx` pin and the host-side register/FIFO logic.

## Interface
- `N`, 8: number of data bits per frame (1..16).
- `M`, 1: number of stop bits (1..2).
- `BAUD_RATE`, 9600: line bit rate in bits/s.
- `CLK_FREQ`, 50000000: `clk` frequency in Hz.
- `clk` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `rx` in 1: serial input, asynchronous to `clk`, idle high.
- `rd` in 1: host read strobe; consumes the held word.
- `data_out` out N: last received data word.
- `data_valid` out 1: `data_out` holds an unread word.
- `frame_err` out 1: a stop bit of the word in `data_out` sampled low.
- `parity_err` out 1: parity mismatch on the word in `data_out` (0 when parity is compiled out).
- `overrun_err` out 1: sticky; a word was overwritten before it was read.
- `busy` out 1: a frame is in progress (state ≠ IDLE).

## Operation
- Synchronizer: 2-flop on `rx`, both flops reset to 1. All logic uses `rx_s`.
- Oversample tick: free-running counter 0..DIV-1 with DIV = CLK_FREQ/(BAUD_RATE*16), integer truncation. `tick` is a 1-clk pulse when the counter reaches DIV-1. The counter resets to 0.
- Sample counter `s_cnt` (4 bit) counts ticks within a bit. The sample point is `s_cnt`==7 during START and ==15 for the following bits, which is mid-bit.
- Arm flag: cleared by reset and by a frame that ends with `frame_err`. It is set on any tick with `rx_s`=1. A start bit is detected only while armed, so a stuck-low line or break is not re-received as a stream of frames.
- FSM states: IDLE, START, DATA, PARITY, STOP. Transitions are evaluated on `tick` only.
  - IDLE: if armed and `rx_s`=0, go to START with `s_cnt`=0.
  - START: at `s_cnt`==7, if `rx_s`=1 it is a false start and the FSM returns to IDLE. Otherwise clear `s_cnt` and `bit_cnt` and go to DATA.
  - DATA: at `s_cnt`==15, shift `rx_s` into the MSB of the shift register (right shift) and increment `bit_cnt`. After bit N-1, go to PARITY if parity is compiled in, else go to STOP.
  - PARITY: at `s_cnt`==15, capture the parity bit and go to STOP.
  - STOP: at `s_cnt`==15, sample the stop bit and OR (NOT `rx_s`) into the frame error. After the Mth stop sample the frame completes and the FSM goes to IDLE. It does not wait for the end of the stop bit.
- Frame completion, registered on the next `clk` edge:
  - `data_out` ← shift register and `data_valid` ← 1.
  - `frame_err` and `parity_err` are loaded for this word.
  - If `data_valid` was already 1 and `rd` is not asserted in the same cycle, `overrun_err` ← 1 and the old word is overwritten.
  - A word with `frame_err` is still delivered.
- Read: `rd` with `data_valid`=1 clears `data_valid` and `overrun_err` on the next edge. `rd` with `data_valid`=0 is ignored. If `rd` coincides with frame completion, the new word wins: `data_valid` stays 1 and `overrun_err` is not set.
- Reset, including mid-frame: the FSM goes to IDLE and the partial frame is discarded. Counters go to 0. `data_out`=0, `data_valid`=0, all error flags 0, `busy`=0, arm=0.

## Timing
- Input latency is 2 clks through the synchronizer. Start detection carries up to 1 tick of jitter.
- `data_valid` rises 1 clk after the tick at which the last stop bit is sampled. Measured from the `rx` falling edge, that is about (1+N+P+M−0.5) bit periods plus 3 clks, where P=1 if parity is compiled in, else 0.
- `busy` goes high 1 clk after the detection tick and goes low on the same edge that sets `data_valid`.
- Back-to-back frames with no idle gap are received without loss. The receiver is back in IDLE half a bit before the stop bit ends.
- Tolerates ±3% baud mismatch at 8N1.

## Configuration
- Macro `UART_RX_PARITY_EN`. When defined: the PARITY state exists and even parity is checked. `parity_err` = (XOR of data bits) ≠ received parity bit.
- When undefined: no parity bit in the frame, the FSM goes DATA→STOP, and `parity_err` is tied to 0.

## Test plan
All scenarios use CLK_FREQ=1600000 and BAUD_RATE=10000, so DIV=10 and one bit = 160 clks, with N=8 and M=1.
- Send 0xA5, 8N1 → `data_valid`=1 about 1523 clks after the start edge. `data_out`=0xA5, all error flags 0. `rd` → `data_valid`=0 on the next clk.
- 0x00 then 0xFF back-to-back with no gap, with `rd` after each → two words delivered in order, no errors.
- Low glitch of 40 clks on idle `rx` → false start, FSM back to IDLE, `data_valid` stays 0, `busy` pulses only.
- Send 0x3C with the stop bit forced to 0, then hold `rx` low for 3000 clks → one word 0x3C with `frame_err`=1. No further words until `rx` returns high.
- Send two frames 0x11 and 0x22 without `rd` → `data_out`=0x22 and `overrun_err`=1. Then `rd` → `overrun_err`=0. Repeat with `rd` asserted exactly on the completion cycle of 0x22 → `overrun_err` stays 0.
- With `UART_RX_PARITY_EN`, send 0x07 with a parity bit of 0 → `parity_err`=1. With a parity bit of 1 → `parity_err`=0. Also assert `reset` mid-DATA → all outputs 0 and the next clean frame is received correctly.
